// File: rtl/native_mem_slave.sv
// -----------------------------------------------------------------------------
// native_mem_slave
//
// Purpose:
//   Slave for the picorv32 native memory interface. It provides a word-addressed
//   RAM with a configurable number of wait states, plus a 16-byte MMIO block:
//     IO_BASE+0x0  CONSOLE      write emits one byte on con_data_o (pulse on
//                               con_valid_o); read returns 0
//     IO_BASE+0x4  GPIO         read/write, byte-lane writes
//     IO_BASE+0x8  CYCLES       read-only free-running cycle counter
//     IO_BASE+0xC  TEST_STATUS  write sets test_done_o and captures the full
//                               word in test_code_o; read returns test_code_o
//   Unmapped addresses and instruction fetches from the MMIO range are illegal.
//   They still complete, but they return 0, change no state and set the sticky
//   error flag. The first illegal address is kept in err_addr_o.
//
// Ports:
//   clk_i          system clock, all logic on the rising edge
//   resetn_i       synchronous active-low reset
//   mem_valid_i    request valid, held by the CPU until mem_ready_o
//   mem_instr_i    request is an instruction fetch
//   mem_ready_o    single-cycle response strobe
//   mem_addr_i     byte address (bits [1:0] ignored for data access)
//   mem_wdata_i    write data
//   mem_wstrb_i    byte write enables, 0 = read
//   mem_rdata_o    read data, valid while mem_ready_o is high
//   con_valid_o    single-cycle pulse when a console byte is written
//   con_data_o     last console byte written
//   gpio_out_o     GPIO register contents
//   test_done_o    sticky, TEST_STATUS has been written
//   test_code_o    last value written to TEST_STATUS
//   err_o          sticky, an illegal access has occurred
//   err_addr_o     address of the first illegal access
// -----------------------------------------------------------------------------
module native_mem_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] IO_BASE     = 32'h1000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        mem_valid_i,
    input  logic        mem_instr_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        con_valid_o,
    output logic [7:0]  con_data_o,
    output logic [31:0] gpio_out_o,
    output logic        test_done_o,
    output logic [31:0] test_code_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // RAM storage (not reset)
    logic [31:0] mem [MEM_WORDS];

    // FSM and response registers
    state_t      state_q;
    logic [3:0]  count_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;

    // Latched request
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;

    // MMIO state
    logic        con_valid_q;
    logic [7:0]  con_data_q;
    logic [31:0] gpio_q;
    logic [31:0] gpio_d;
    logic [31:0] cycles_q;
    logic [31:0] cycles_d;
    logic        test_done_q;
    logic [31:0] test_code_q;
    logic        err_q;
    logic [31:0] err_addr_q;

    // Decode of the latched request
    logic          accept;
    logic          ram_hit;
    logic          io_hit;
    logic          illegal;
    logic          is_write;
    logic          ram_we;
    logic [AW-1:0] ram_idx;
    logic [1:0]    io_reg;

    // A new request is taken only from IDLE and never during the cycle in which
    // the previous response is still visible; otherwise a mem_valid that the CPU
    // has not yet dropped would be issued a second time.
    assign accept = (state_q == S_IDLE) && mem_valid_i && !mem_ready_q;

    // BASE_ADDR is aligned to the RAM size, so an upper-bit compare is the same
    // as the range check and cannot overflow at the top of the address space.
    assign ram_hit  = (addr_q[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign io_hit   = (addr_q[31:4] == IO_BASE[31:4]);
    assign illegal  = io_hit ? instr_q : !ram_hit;
    assign is_write = (wstrb_q != 4'b0000);
    assign ram_idx  = addr_q[AW+1:2];
    assign io_reg   = addr_q[3:2];

    // The RAM write is committed on the edge that raises mem_ready. A reset on
    // that edge drops the write.
    assign ram_we = resetn_i && (state_q == S_RESP) && ram_hit && is_write;

    always_comb begin
        gpio_d = gpio_q;
        for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) begin
                gpio_d[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    assign cycles_d = cycles_q + 32'd1;

    always_ff @(posedge clk_i) begin
        if (resetn_i && accept) begin
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            wstrb_q <= mem_wstrb_i;
            instr_q <= mem_instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            con_valid_q <= 1'b0;
            con_data_q  <= 8'h0;
            gpio_q      <= 32'h0;
            cycles_q    <= 32'h0;
            test_done_q <= 1'b0;
            test_code_q <= 32'h0;
            err_q       <= 1'b0;
            err_addr_q  <= 32'h0;
        end else begin
            cycles_q    <= cycles_d;
            mem_ready_q <= 1'b0;
            con_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (WAIT_CYCLES > 0) begin
                            state_q <= S_WAIT;
                            count_q <= 4'(WAIT_CYCLES);
                        end else begin
                            state_q <= S_RESP;
                        end
                    end
                end

                S_WAIT: begin
                    count_q <= count_q - 4'd1;
                    if (count_q == 4'd1) begin
                        state_q <= S_RESP;
                    end
                end

                S_RESP: begin
                    state_q     <= S_IDLE;
                    mem_ready_q <= 1'b1;
                    mem_rdata_q <= 32'h0;
                    if (illegal) begin
                        err_q <= 1'b1;
                        if (!err_q) begin
                            err_addr_q <= addr_q;
                        end
                    end else if (ram_hit) begin
                        // Registered read of the word before this access's write.
                        mem_rdata_q <= mem[ram_idx];
                    end else begin
                        case (io_reg)
                            2'd0: begin
                                if (is_write) begin
                                    con_valid_q <= 1'b1;
                                    con_data_q  <= wdata_q[7:0];
                                end
                            end
                            2'd1: begin
                                mem_rdata_q <= gpio_q;
                                if (is_write) begin
                                    gpio_q <= gpio_d;
                                end
                            end
                            2'd2: begin
                                mem_rdata_q <= cycles_q;
                            end
                            default: begin
                                // TEST_STATUS always takes the whole word.
                                mem_rdata_q <= test_code_q;
                                if (is_write) begin
                                    test_done_q <= 1'b1;
                                    test_code_q <= wdata_q;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready_o = mem_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign con_valid_o = con_valid_q;
    assign con_data_o  = con_data_q;
    assign gpio_out_o  = gpio_q;
    assign test_done_o = test_done_q;
    assign test_code_o = test_code_q;
    assign err_o       = err_q;
    assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_native_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_native_mem_slave
//   Directed bench for native_mem_slave. Two instances run side by side: dut0
//   has no wait states and dut3 has three. Each has its own request signals.
// -----------------------------------------------------------------------------
module tb_native_mem_slave;

    localparam logic [31:0] IO = 32'h1000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 signals (WAIT_CYCLES = 0)
    logic        rstn0, valid0, instr0, ready0, con_valid0, test_done0, err0;
    logic [31:0] addr0, wdata0, rdata0, gpio0, test_code0, err_addr0;
    logic [3:0]  wstrb0;
    logic [7:0]  con_data0;

    // dut3 signals (WAIT_CYCLES = 3)
    logic        rstn3, valid3, instr3, ready3, con_valid3, test_done3, err3;
    logic [31:0] addr3, wdata3, rdata3, gpio3, test_code3, err_addr3;
    logic [3:0]  wstrb3;
    logic [7:0]  con_data3;

    int checks = 0;
    int errors = 0;

    native_mem_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .IO_BASE(IO), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i(clk), .resetn_i(rstn0), .mem_valid_i(valid0), .mem_instr_i(instr0),
        .mem_ready_o(ready0), .mem_addr_i(addr0), .mem_wdata_i(wdata0), .mem_wstrb_i(wstrb0),
        .mem_rdata_o(rdata0), .con_valid_o(con_valid0), .con_data_o(con_data0),
        .gpio_out_o(gpio0), .test_done_o(test_done0), .test_code_o(test_code0),
        .err_o(err0), .err_addr_o(err_addr0)
    );

    native_mem_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0), .IO_BASE(IO), .WAIT_CYCLES(3)) u_dut3 (
        .clk_i(clk), .resetn_i(rstn3), .mem_valid_i(valid3), .mem_instr_i(instr3),
        .mem_ready_o(ready3), .mem_addr_i(addr3), .mem_wdata_i(wdata3), .mem_wstrb_i(wstrb3),
        .mem_rdata_o(rdata3), .con_valid_o(con_valid3), .con_data_o(con_data3),
        .gpio_out_o(gpio3), .test_done_o(test_done3), .test_code_o(test_code3),
        .err_o(err3), .err_addr_o(err_addr3)
    );

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ready0 : ready3;
    endfunction

    // One complete request. lat counts rising edges from driving mem_valid to
    // seeing mem_ready (WAIT_CYCLES + 2), or -1 if no response came.
    task automatic txn(input int sel, input logic instr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] rdata, output int lat, output logic cv);
        bit done = 1'b0;
        rdata = 32'h0;
        lat   = -1;
        cv    = 1'b0;
        @(negedge clk);
        if (sel == 0) begin
            valid0 = 1'b1; instr0 = instr; addr0 = addr; wdata0 = wdata; wstrb0 = wstrb;
        end else begin
            valid3 = 1'b1; instr3 = instr; addr3 = addr; wdata3 = wdata; wstrb3 = wstrb;
        end
        for (int i = 1; i <= 40 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy(sel)) begin
                done  = 1'b1;
                lat   = i;
                rdata = (sel == 0) ? rdata0 : rdata3;
                cv    = (sel == 0) ? con_valid0 : con_valid3;
            end
        end
        if (sel == 0) begin valid0 = 1'b0; wstrb0 = 4'h0; instr0 = 1'b0; end
        else begin valid3 = 1'b0; wstrb3 = 4'h0; instr3 = 1'b0; end
    endtask

    task automatic test_reset();
        rstn0 = 1'b0; rstn3 = 1'b0;
        valid0 = 1'b0; instr0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
        valid3 = 1'b0; instr3 = 1'b0; addr3 = '0; wdata3 = '0; wstrb3 = '0;
        repeat (3) @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready0); end
        checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata0); end
        checks++; if (con_valid0 !== 1'b0) begin errors++; $display("FAIL reset_con_valid got %b want 0", con_valid0); end
        checks++; if (con_data0 !== 8'h0) begin errors++; $display("FAIL reset_con_data got %h want 0", con_data0); end
        checks++; if (gpio0 !== 32'h0) begin errors++; $display("FAIL reset_gpio got %h want 0", gpio0); end
        checks++; if (test_done0 !== 1'b0) begin errors++; $display("FAIL reset_test_done got %b want 0", test_done0); end
        checks++; if (test_code0 !== 32'h0) begin errors++; $display("FAIL reset_test_code got %h want 0", test_code0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err0); end
        checks++; if (err_addr0 !== 32'h0) begin errors++; $display("FAIL reset_err_addr got %h want 0", err_addr0); end
        checks++; if (ready3 !== 1'b0 || err3 !== 1'b0) begin errors++; $display("FAIL reset_dut3 got ready=%b err=%b want 0 0", ready3, err3); end
        rstn0 = 1'b1; rstn3 = 1'b1;
    endtask

    task automatic test_ram_wait0();
        logic [31:0] rd; int lat; logic cv;
        txn(0, 1'b0, 32'h3FC, 32'h1234_5678, 4'hF, rd, lat, cv);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w0_write_latency got %0d want 2", lat); end
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (lat !== 2) begin errors++; $display("FAIL w0_read_latency got %0d want 2", lat); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL w0_read_data got %h want 12345678", rd); end
        @(negedge clk);
        checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL w0_ready_pulse got %b want 0", ready0); end
        txn(0, 1'b0, 32'h3FC, 32'hCAFE_F00D, 4'hF, rd, lat, cv);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL w0_prewrite_data got %h want 12345678", rd); end
        txn(0, 1'b1, 32'h3FC, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL w0_fetch_data got %h want cafef00d", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat; logic cv;
        txn(0, 1'b0, 32'h10, 32'h1122_3344, 4'hF, rd, lat, cv);
        txn(0, 1'b0, 32'h10, 32'hAABB_CCDD, 4'b0100, rd, lat, cv);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'h11BB_3344) begin errors++; $display("FAIL byte_lane got %h want 11bb3344", rd); end
    endtask

    task automatic test_wait3();
        logic [31:0] rd; int lat; logic cv;
        txn(3, 1'b0, 32'h0, 32'hA5A5_0001, 4'hF, rd, lat, cv);
        checks++; if (lat !== 5) begin errors++; $display("FAIL w3_write_latency got %0d want 5", lat); end
        txn(3, 1'b0, 32'h0, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (lat !== 5) begin errors++; $display("FAIL w3_read_latency got %0d want 5", lat); end
        checks++; if (rd !== 32'hA5A5_0001) begin errors++; $display("FAIL w3_read_data got %h want a5a50001", rd); end
        @(negedge clk);
        checks++; if (ready3 !== 1'b0) begin errors++; $display("FAIL w3_ready_pulse got %b want 0", ready3); end
    endtask

    task automatic test_mmio();
        logic [31:0] rd, c1; int lat; logic cv;
        txn(0, 1'b0, IO, 32'h0000_0041, 4'b0001, rd, lat, cv);
        checks++; if (cv !== 1'b1) begin errors++; $display("FAIL con_valid_pulse got %b want 1", cv); end
        @(negedge clk);
        checks++; if (con_valid0 !== 1'b0) begin errors++; $display("FAIL con_valid_clear got %b want 0", con_valid0); end
        checks++; if (con_data0 !== 8'h41) begin errors++; $display("FAIL con_data got %h want 41", con_data0); end
        txn(0, 1'b0, IO, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'h0 || cv !== 1'b0) begin errors++; $display("FAIL con_read got %h/%b want 0/0", rd, cv); end
        txn(0, 1'b0, IO + 32'h4, 32'h1122_3344, 4'hF, rd, lat, cv);
        txn(0, 1'b0, IO + 32'h4, 32'hFFFF_FFFF, 4'b0010, rd, lat, cv);
        txn(0, 1'b0, IO + 32'h4, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'h1122_FF44) begin errors++; $display("FAIL gpio_read got %h want 1122ff44", rd); end
        checks++; if (gpio0 !== 32'h1122_FF44) begin errors++; $display("FAIL gpio_out got %h want 1122ff44", gpio0); end
        txn(0, 1'b0, IO + 32'hC, 32'h0000_0001, 4'hF, rd, lat, cv);
        checks++; if (test_done0 !== 1'b1 || test_code0 !== 32'h1) begin errors++; $display("FAIL test_status got %b/%h want 1/1", test_done0, test_code0); end
        txn(0, 1'b0, IO + 32'hC, 32'h0000_0102, 4'b0001, rd, lat, cv);
        checks++; if (test_code0 !== 32'h0000_0102) begin errors++; $display("FAIL test_code_fullword got %h want 102", test_code0); end
        txn(0, 1'b0, IO + 32'hC, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'h0000_0102) begin errors++; $display("FAIL test_status_read got %h want 102", rd); end
        // Two back-to-back CYCLES reads land three clock edges apart.
        txn(0, 1'b0, IO + 32'h8, 32'h0, 4'h0, c1, lat, cv);
        txn(0, 1'b0, IO + 32'h8, 32'hFFFF_FFFF, 4'hF, rd, lat, cv);
        checks++; if (rd - c1 !== 32'd3) begin errors++; $display("FAIL cycles_delta got %0d want 3", rd - c1); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; int lat; logic cv;
        txn(0, 1'b0, 32'h2000_0000, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (lat !== 2 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_resp got lat=%0d rd=%h want 2 0", lat, rd); end
        checks++; if (err0 !== 1'b1 || err_addr0 !== 32'h2000_0000) begin errors++; $display("FAIL unmapped_err got %b/%h want 1/20000000", err0, err_addr0); end
        txn(0, 1'b1, IO + 32'hC, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (lat !== 2 || rd !== 32'h0) begin errors++; $display("FAIL io_fetch_resp got lat=%0d rd=%h want 2 0", lat, rd); end
        checks++; if (err0 !== 1'b1 || err_addr0 !== 32'h2000_0000) begin errors++; $display("FAIL first_err_wins got %b/%h want 1/20000000", err0, err_addr0); end
        txn(0, 1'b0, 32'h3000_0000, 32'hFFFF_FFFF, 4'hF, rd, lat, cv);
        txn(0, 1'b0, IO + 32'h4, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'h1122_FF44 || err_addr0 !== 32'h2000_0000) begin errors++; $display("FAIL illegal_no_change got %h/%h want 1122ff44/20000000", rd, err_addr0); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int lat; logic cv; logic seen;
        txn(3, 1'b0, 32'h8, 32'h1111_2222, 4'hF, rd, lat, cv);
        @(negedge clk);
        valid3 = 1'b1; addr3 = 32'h8; wdata3 = 32'hDEAD_BEEF; wstrb3 = 4'hF;
        repeat (2) @(negedge clk);
        rstn3 = 1'b0; valid3 = 1'b0; wstrb3 = 4'h0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready3 !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got %b want 0", seen); end
        rstn3 = 1'b1;
        txn(3, 1'b0, IO + 32'h8, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL cycles_after_reset got %0d want 5", rd); end
        txn(3, 1'b0, 32'h8, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (lat !== 5 || rd !== 32'h1111_2222) begin errors++; $display("FAIL reset_mid_ram got lat=%0d rd=%h want 5 11112222", lat, rd); end
    endtask

    task automatic test_reset_collision();
        logic [31:0] rd; int lat; logic cv; logic seen;
        @(negedge clk);
        rstn0 = 1'b0; valid0 = 1'b1; addr0 = 32'h3FC; wdata0 = 32'h0; wstrb0 = 4'hF;
        @(negedge clk);
        rstn0 = 1'b1; valid0 = 1'b0; wstrb0 = 4'h0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready0 !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL collision_ready got %b want 0", seen); end
        checks++; if (gpio0 !== 32'h0 || err0 !== 1'b0 || test_done0 !== 1'b0) begin errors++; $display("FAIL collision_clear got %h/%b/%b want 0/0/0", gpio0, err0, test_done0); end
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, lat, cv);
        checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL collision_ram got %h want cafef00d", rd); end
    endtask

    initial begin
        test_reset();
        test_ram_wait0();
        test_byte_lanes();
        test_wait3();
        test_mmio();
        test_illegal();
        test_reset_mid();
        test_reset_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
